filter_rx_pipeline: RTL and testbench
=====================================

Name: filter_rx_pipeline

Overview:
- Receive-path packet filter between the CMAC/adapter AXI4-Stream (512-bit) and the QDMA C2H stream.
- Parses the first beat of each Ethernet frame for the IPv4/IPv6 destination address and the TCP/UDP destination port.
- Compares these fields against NUM_RULES configured rules, forwards matching packets whole and drops non-matching packets whole.
- Exposes packet counters through status_reg.

Parameters:
- NUM_RULES, 2: number of active filter rules. Must satisfy 1 <= NUM_RULES <= cfg_reg_pkg::MAX_FILTER_RULES.

Ports:
- aclk  in  1  single clock for everything.
- areset  in  1  asynchronous, active-high reset.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input ready.
- s_axis_tdata  in  512  input data; byte 0 (first on wire) = bits 7:0.
- s_axis_tkeep  in  64  input byte enables.
- s_axis_tlast  in  1  last beat of the packet.
- s_axis_tuser  in  48  sideband; passed through unchanged.
- m_axis_tvalid / m_axis_tready / m_axis_tdata(512) / m_axis_tkeep(64) / m_axis_tlast / m_axis_tuser(48): output stream, same semantics; tvalid, tdata, tkeep, tlast, tuser are outputs and tready is an input.
- cfg_reg  in  cfg_reg_t  rule table: filter_rules[i].ipv4_addr(32), ipv6_addr(128), port(32).
- status_reg  out  status_reg_t  counters.

Behaviour:
- Single output register stage. Latency is 1 cycle from input acceptance to m_axis_tvalid.
- s_axis_tready = !out_valid || m_axis_tready.
- Output beat fields are held stable while m_axis_tvalid && !m_axis_tready.
- Reset (async): m_axis_tvalid=0, in_packet=0, drop flag=0, all counters=0. Data outputs reset to 0.
- Reset mid-packet: the partial packet is lost, and the next accepted beat is treated as a first beat.
- First beat is the beat accepted while in_packet=0. The in_packet flag sets on a non-last accepted beat and clears on an accepted tlast.
- Header parsing uses big-endian byte fields:
  - EtherType at bytes 12-13.
  - IPv4 (0x0800): protocol at byte 23, dst addr at bytes 30-33, dst port at bytes 36-37. The port is valid only if IHL (byte 14, low nibble) == 5 and protocol is 6 or 17.
  - IPv6 (0x86DD): next header at byte 20, dst addr at bytes 38-53, dst port at bytes 56-57. The port is valid only if next header is 6 or 17.
  - Any other EtherType (including VLAN-tagged frames) is non-IP.
- Rule i matches when:
  - IPv4 packet: (ipv4_addr==0 || ipv4_addr==dst4) && port condition.
  - IPv6 packet: ipv6_addr!=0 && ipv6_addr==dst6 && port condition.
  - Port condition: port==0, or (port valid && port[15:0]==dport).
  - Non-IP packets never match.
- Pass = OR of all rule matches. Hit rule = lowest matching index.
- The decision is computed combinationally on the first beat and latched for the rest of the packet.
- Dropped beats are accepted (tready as above) but never presented on the output.
- cfg_reg is sampled only on first beats; changes mid-packet do not affect that packet.
- A single-beat packet (first beat with tlast) is decided and completed in the same cycle.

Counters (32-bit, wrap on overflow), each updated on the accepted tlast beat:
- rx_pkt_count: every packet.
- tx_pkt_count: passed packets.
- drop_pkt_count: dropped packets.
- rule_hit_count[i]: packets whose hit rule is i.

Optional Feature:
- FILTER_STATS_EN defined: counters are implemented as above.
- FILTER_STATS_EN undefined: no counter logic; status_reg is driven to all zeros. Datapath behaviour is identical in both builds.

Decomposition:
- Package cfg_reg_pkg holds:
  - MAX_FILTER_RULES = 2.
  - filter_rule_t {ipv4_addr, ipv6_addr, port}.
  - cfg_reg_t {filter_rules[MAX_FILTER_RULES]}.
  - status_reg_t {rx_pkt_count, tx_pkt_count, drop_pkt_count, rule_hit_count[MAX_FILTER_RULES]}.
  - ETHERTYPE_IPV4/IPV6, PROTO_TCP/UDP constants.
- Sub-module filter_rule_match: one rule plus parsed header fields -> match bit. It is instantiated NUM_RULES times.

Test Plan:
- Rule0 = {C0A80001, 0, 0x50} and rule1 = {0, 0, 0}. Send an IPv4 TCP packet to 192.168.0.1:80, 3 beats -> all 3 beats out with a 1-cycle latency, tdata, tkeep and tuser unchanged; rule_hit_count[0]=1 and tx_pkt_count=1.
- Same rules, IPv4 UDP packet to 10.0.0.5:53 -> passes via rule1; rule_hit_count[1]=1.
- Rule1 cleared to port=0x1234. Send an IPv4 packet to 10.0.0.5:53 -> no output beats; drop_pkt_count=1; s_axis_tready stays 1.
- IPv6 packet with any address (both ipv6_addr=0), and an ARP frame (0x0806) -> both dropped; rx_pkt_count=2.
- m_axis_tready toggled 1-0-1 every cycle during a passing 4-beat packet -> no beat lost or duplicated; outputs stable while stalled.
- areset asserted mid-packet -> m_axis_tvalid=0 immediately and counters=0. The next packet is parsed correctly from its first beat.

Source files
------------

// File: rtl/cfg_reg_pkg.sv
// Shared types, constants and header-parse helpers for the receive-path packet filter.
package cfg_reg_pkg;

  localparam int MAX_FILTER_RULES = 2;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETHERTYPE_IPV6 = 16'h86DD;
  localparam logic [7:0]  PROTO_TCP      = 8'd6;
  localparam logic [7:0]  PROTO_UDP      = 8'd17;

  typedef struct packed {
    logic [31:0]  ipv4_addr;
    logic [127:0] ipv6_addr;
    logic [31:0]  port;
  } filter_rule_t;

  typedef struct packed {
    filter_rule_t [MAX_FILTER_RULES-1:0] filter_rules;
  } cfg_reg_t;

  typedef struct packed {
    logic [31:0]                        rx_pkt_count;
    logic [31:0]                        tx_pkt_count;
    logic [31:0]                        drop_pkt_count;
    logic [MAX_FILTER_RULES-1:0][31:0]  rule_hit_count;
  } status_reg_t;

  typedef struct packed {
    logic         is_ipv4;
    logic         is_ipv6;
    logic [31:0]  dst4;
    logic [127:0] dst6;
    logic         port_vld;
    logic [15:0]  dport;
  } hdr_t;

  function automatic logic [7:0] byte_at(input logic [511:0] d, input int idx);
    return d[8*idx +: 8];
  endfunction

  function automatic logic is_l4(input logic [7:0] proto);
    return (proto == PROTO_TCP) || (proto == PROTO_UDP);
  endfunction

  // Byte 0 is the first byte on the wire; multi-byte fields are big-endian.
  function automatic hdr_t parse_hdr(input logic [511:0] d);
    hdr_t        h;
    logic [15:0] etype;
    h       = '0;
    etype   = {byte_at(d, 12), byte_at(d, 13)};
    h.is_ipv4 = (etype == ETHERTYPE_IPV4);
    h.is_ipv6 = (etype == ETHERTYPE_IPV6);
    if (h.is_ipv4) begin
      h.dst4     = {byte_at(d, 30), byte_at(d, 31), byte_at(d, 32), byte_at(d, 33)};
      h.dport    = {byte_at(d, 36), byte_at(d, 37)};
      h.port_vld = (d[8*14 +: 4] == 4'd5) && is_l4(byte_at(d, 23));
    end else if (h.is_ipv6) begin
      for (int k = 0; k < 16; k++) h.dst6[127-8*k -: 8] = byte_at(d, 38 + k);
      h.dport    = {byte_at(d, 56), byte_at(d, 57)};
      h.port_vld = is_l4(byte_at(d, 20));
    end
    return h;
  endfunction

endpackage

// File: rtl/filter_rule_match.sv
// Evaluates one filter rule against the parsed header of a first beat.
module filter_rule_match
  import cfg_reg_pkg::*;
(
  input  filter_rule_t rule,
  input  hdr_t         hdr,
  output logic         match
);

  logic port_ok;

  assign port_ok = (rule.port == '0) ||
                   (hdr.port_vld && (rule.port[15:0] == hdr.dport));

  // A zero IPv4 address is a wildcard; a zero IPv6 address disables the rule for IPv6.
  always_comb begin
    match = 1'b0;
    if (hdr.is_ipv4)
      match = ((rule.ipv4_addr == '0) || (rule.ipv4_addr == hdr.dst4)) && port_ok;
    else if (hdr.is_ipv6)
      match = (rule.ipv6_addr != '0) && (rule.ipv6_addr == hdr.dst6) && port_ok;
  end

endmodule

// File: rtl/filter_rx_pipeline.sv
// RX packet filter: whole-packet pass/drop on first-beat header match, one output register stage.
// Define FILTER_STATS_EN to build the packet counters; otherwise status_reg reads as zero.
module filter_rx_pipeline
  import cfg_reg_pkg::*;
#(
  parameter int NUM_RULES = 2
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  input  logic [511:0] s_axis_tdata,
  input  logic [63:0]  s_axis_tkeep,
  input  logic         s_axis_tlast,
  input  logic [47:0]  s_axis_tuser,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic [511:0] m_axis_tdata,
  output logic [63:0]  m_axis_tkeep,
  output logic         m_axis_tlast,
  output logic [47:0]  m_axis_tuser,
  input  cfg_reg_t     cfg_reg,
  output status_reg_t  status_reg
);

  // Stage p0: header parse and rule match on the incoming beat
  hdr_t                 hdr_p0;
  logic [NUM_RULES-1:0] match_p0;
  logic                 accept_p0;
  logic                 pass_p0;
  logic                 in_packet;
  logic                 pass_q;
  logic                 vld_p1;

  assign hdr_p0 = parse_hdr(s_axis_tdata);

  for (genvar g = 0; g < NUM_RULES; g++) begin : g_rule
    filter_rule_match u_match (
      .rule  (cfg_reg.filter_rules[g]),
      .hdr   (hdr_p0),
      .match (match_p0[g])
    );
  end

  assign s_axis_tready = !vld_p1 || m_axis_tready;
  assign accept_p0     = s_axis_tvalid && s_axis_tready;
  // Continuation beats follow the decision latched on the first beat.
  assign pass_p0       = in_packet ? pass_q : |match_p0;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      in_packet <= 1'b0;
      pass_q    <= 1'b0;
    end else if (accept_p0) begin
      in_packet <= !s_axis_tlast;
      if (!in_packet) pass_q <= |match_p0;
    end
  end

  // Stage p1: output register, held while the sink stalls
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      vld_p1       <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tkeep <= '0;
      m_axis_tlast <= 1'b0;
      m_axis_tuser <= '0;
    end else if (s_axis_tready) begin
      vld_p1 <= accept_p0 && pass_p0;
      if (accept_p0 && pass_p0) begin
        m_axis_tdata <= s_axis_tdata;
        m_axis_tkeep <= s_axis_tkeep;
        m_axis_tlast <= s_axis_tlast;
        m_axis_tuser <= s_axis_tuser;
      end
    end
  end

  assign m_axis_tvalid = vld_p1;

`ifdef FILTER_STATS_EN
  localparam int HIT_W = (MAX_FILTER_RULES > 1) ? $clog2(MAX_FILTER_RULES) : 1;

  logic [HIT_W-1:0] hit_first_p0;
  logic [HIT_W-1:0] hit_p0;
  logic [HIT_W-1:0] hit_q;
  status_reg_t      stats_q;

  // Lowest matching rule index wins.
  always_comb begin
    hit_first_p0 = '0;
    for (int i = NUM_RULES - 1; i >= 0; i--)
      if (match_p0[i]) hit_first_p0 = HIT_W'(i);
  end

  assign hit_p0 = in_packet ? hit_q : hit_first_p0;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      hit_q   <= '0;
      stats_q <= '0;
    end else if (accept_p0) begin
      if (!in_packet) hit_q <= hit_first_p0;
      if (s_axis_tlast) begin
        stats_q.rx_pkt_count <= stats_q.rx_pkt_count + 32'd1;
        if (pass_p0) begin
          stats_q.tx_pkt_count           <= stats_q.tx_pkt_count + 32'd1;
          stats_q.rule_hit_count[hit_p0] <= stats_q.rule_hit_count[hit_p0] + 32'd1;
        end else begin
          stats_q.drop_pkt_count <= stats_q.drop_pkt_count + 32'd1;
        end
      end
    end
  end

  assign status_reg = stats_q;
`else
  assign status_reg = '0;
`endif

endmodule

// File: tb/tb_filter_rx_pipeline.sv
// Directed bench for filter_rx_pipeline; counter expectations follow FILTER_STATS_EN.
module tb_filter_rx_pipeline;
  import cfg_reg_pkg::*;

`ifdef FILTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         aclk = 1'b0;
  logic         areset;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [511:0] s_axis_tdata;
  logic [63:0]  s_axis_tkeep;
  logic         s_axis_tlast;
  logic [47:0]  s_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic         m_axis_tlast;
  logic [47:0]  m_axis_tuser;
  cfg_reg_t     cfg;
  status_reg_t  status_reg;

  int n_checks = 0;
  int n_fail   = 0;

  filter_rx_pipeline #(.NUM_RULES(2)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .cfg_reg       (cfg),
    .status_reg    (status_reg)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt(input int v);
    return STATS ? v[31:0] : 32'd0;
  endfunction

  task automatic chk_stats(input string tag, input int rx, input int tx, input int drop,
                           input int h0, input int h1);
    chk({tag, "/rx"},   status_reg.rx_pkt_count,      cnt(rx));
    chk({tag, "/tx"},   status_reg.tx_pkt_count,      cnt(tx));
    chk({tag, "/drop"}, status_reg.drop_pkt_count,    cnt(drop));
    chk({tag, "/hit0"}, status_reg.rule_hit_count[0], cnt(h0));
    chk({tag, "/hit1"}, status_reg.rule_hit_count[1], cnt(h1));
  endtask

  task automatic set_rule(input int idx, input logic [31:0] v4, input logic [127:0] v6,
                          input logic [31:0] port);
    cfg.filter_rules[idx].ipv4_addr = v4;
    cfg.filter_rules[idx].ipv6_addr = v6;
    cfg.filter_rules[idx].port      = port;
  endtask

  function automatic logic [511:0] fill(input logic [31:0] w);
    return {16{w}};
  endfunction

  function automatic logic [511:0] ipv4_hdr(input logic [31:0] dst, input logic [7:0] proto,
                                            input logic [15:0] dport, input logic [3:0] ihl);
    logic [511:0] d;
    d = fill(32'h0102_0304);
    d[8*12 +: 8] = 8'h08;  d[8*13 +: 8] = 8'h00;
    d[8*14 +: 8] = {4'h4, ihl};
    d[8*23 +: 8] = proto;
    d[8*30 +: 8] = dst[31:24]; d[8*31 +: 8] = dst[23:16];
    d[8*32 +: 8] = dst[15:8];  d[8*33 +: 8] = dst[7:0];
    d[8*36 +: 8] = dport[15:8]; d[8*37 +: 8] = dport[7:0];
    return d;
  endfunction

  function automatic logic [511:0] ipv6_hdr(input logic [127:0] dst, input logic [7:0] nh,
                                            input logic [15:0] dport);
    logic [511:0] d;
    d = fill(32'h0506_0708);
    d[8*12 +: 8] = 8'h86;  d[8*13 +: 8] = 8'hDD;
    d[8*20 +: 8] = nh;
    for (int k = 0; k < 16; k++) d[8*(38+k) +: 8] = dst[127-8*k -: 8];
    d[8*56 +: 8] = dport[15:8]; d[8*57 +: 8] = dport[7:0];
    return d;
  endfunction

  // Drive one beat with the sink ready; the beat must appear one cycle later iff pass.
  task automatic send_beat(input string tag, input logic [511:0] d, input logic [63:0] k,
                           input logic l, input logic [47:0] u, input logic pass);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    #1;
    chk({tag, "/s_tready"}, s_axis_tready, 1'b1);
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    chk({tag, "/m_tvalid"}, m_axis_tvalid, pass);
    if (pass) begin
      chk({tag, "/tdata"}, m_axis_tdata, d);
      chk({tag, "/tkeep"}, m_axis_tkeep, k);
      chk({tag, "/tlast"}, m_axis_tlast, l);
      chk({tag, "/tuser"}, m_axis_tuser, u);
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge aclk);
    chk({tag, "/idle_tvalid"}, m_axis_tvalid, 1'b0);
  endtask

  logic [511:0] bp_beats [4];
  logic [511:0] prev_data;
  logic         prev_last;
  logic         prev_stall;
  int           in_idx, out_idx, cyc;

  initial begin
    areset = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
    s_axis_tlast = 1'b0;  s_axis_tuser = '0; m_axis_tready = 1'b1;
    cfg = '0;
    set_rule(0, 32'hC0A8_0001, '0, 32'h50);
    set_rule(1, 32'h0, '0, 32'h0);
    @(negedge aclk); @(negedge aclk);
    chk("reset/m_tvalid", m_axis_tvalid, 1'b0);
    chk("reset/tdata", m_axis_tdata, '0);
    chk("reset/s_tready", s_axis_tready, 1'b1);
    chk_stats("reset", 0, 0, 0, 0, 0);
    areset = 1'b0;

    // IPv4 TCP to 192.168.0.1:80, three beats, hits rule 0
    send_beat("A0", ipv4_hdr(32'hC0A8_0001, PROTO_TCP, 16'd80, 4'd5), '1, 1'b0, 48'hABCD_0000_0001, 1'b1);
    send_beat("A1", fill(32'hA1A1_0001), '1, 1'b0, 48'hABCD_0000_0002, 1'b1);
    send_beat("A2", fill(32'hA1A1_0002), 64'h0000_00FF_FFFF_FFFF, 1'b1, 48'hABCD_0000_0003, 1'b1);
    idle_check("A");
    chk_stats("A", 1, 1, 0, 1, 0);

    // IPv4 UDP to 10.0.0.5:53 misses rule 0, hits the wildcard rule 1
    send_beat("B0", ipv4_hdr(32'h0A00_0005, PROTO_UDP, 16'd53, 4'd5), '1, 1'b0, 48'h1111_2222_3333, 1'b1);
    send_beat("B1", fill(32'hB1B1_0001), 64'hFFFF, 1'b1, 48'h4444_5555_6666, 1'b1);
    idle_check("B");
    chk_stats("B", 2, 2, 0, 1, 1);

    // Rule 1 narrowed to port 0x1234: same flow is dropped; mid-packet rule change is ignored
    set_rule(1, 32'h0, '0, 32'h1234);
    send_beat("C0", ipv4_hdr(32'h0A00_0005, PROTO_UDP, 16'd53, 4'd5), '1, 1'b0, 48'h7, 1'b0);
    set_rule(0, 32'h0, '0, 32'h0);
    send_beat("C1", fill(32'hC1C1_0001), '1, 1'b1, 48'h8, 1'b0);
    set_rule(0, 32'hC0A8_0001, '0, 32'h50);
    idle_check("C");
    chk_stats("C", 3, 2, 1, 1, 1);

    // Single-beat IPv6, ARP and IPv4-with-options frames are all dropped
    send_beat("V6", ipv6_hdr(128'h2001_0DB8_0000_0000_0000_0000_0000_0001, PROTO_TCP, 16'd80),
              '1, 1'b1, 48'h9, 1'b0);
    begin
      logic [511:0] arp;
      arp = fill(32'h0A0B_0C0D);
      arp[8*12 +: 8] = 8'h08; arp[8*13 +: 8] = 8'h06;
      send_beat("ARP", arp, '1, 1'b1, 48'hA, 1'b0);
    end
    send_beat("IHL6", ipv4_hdr(32'hC0A8_0001, PROTO_TCP, 16'd80, 4'd6), '1, 1'b1, 48'hB, 1'b0);
    idle_check("D");
    chk_stats("D", 6, 2, 4, 1, 1);

    // Four-beat passing packet with the sink toggling ready 1-0-1
    for (int i = 0; i < 4; i++)
      bp_beats[i] = (i == 0) ? ipv4_hdr(32'hC0A8_0001, PROTO_TCP, 16'd80, 4'd5)
                             : fill(32'hB0B0_0000 + i);
    in_idx = 0; out_idx = 0; cyc = 0; prev_stall = 1'b0;
    prev_data = '0; prev_last = 1'b0;
    while (out_idx < 4 && cyc < 40) begin
      if (prev_stall) begin
        chk("bp/hold_tvalid", m_axis_tvalid, 1'b1);
        chk("bp/hold_tdata", m_axis_tdata, prev_data);
        chk("bp/hold_tlast", m_axis_tlast, prev_last);
      end
      m_axis_tready = (cyc % 2 == 0);
      if (in_idx < 4) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = bp_beats[in_idx];
        s_axis_tkeep  = '1;
        s_axis_tlast  = (in_idx == 3);
        s_axis_tuser  = 48'(in_idx);
      end else begin
        s_axis_tvalid = 1'b0;
      end
      #1;
      if (s_axis_tvalid && s_axis_tready) in_idx++;
      if (m_axis_tvalid && m_axis_tready) begin
        chk("bp/tdata", m_axis_tdata, bp_beats[out_idx]);
        chk("bp/tlast", m_axis_tlast, (out_idx == 3));
        out_idx++;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      @(negedge aclk);
      cyc++;
    end
    chk("bp/beats_out", out_idx, 4);
    chk("bp/no_dup", m_axis_tvalid, 1'b0);
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    chk_stats("bp", 7, 3, 4, 2, 1);

    // Asynchronous reset in the middle of a packet
    send_beat("R0", ipv4_hdr(32'hC0A8_0001, PROTO_TCP, 16'd80, 4'd5), '1, 1'b0, 48'hC, 1'b1);
    #2;
    areset = 1'b1;
    #1;
    chk("rst/m_tvalid", m_axis_tvalid, 1'b0);
    chk("rst/tdata", m_axis_tdata, '0);
    chk_stats("rst", 0, 0, 0, 0, 0);
    @(negedge aclk);
    areset = 1'b0;
    send_beat("E0", ipv4_hdr(32'hC0A8_0001, PROTO_UDP, 16'd80, 4'd5), '1, 1'b0, 48'hD, 1'b1);
    send_beat("E1", fill(32'hE1E1_0001), 64'hF, 1'b1, 48'hE, 1'b1);
    idle_check("E");
    chk_stats("E", 1, 1, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
